// File: rtl/pio_pwm_driver.sv
// PWM generator whose duty follows a PIO target word, either jumping straight to it
// or ramping by a fixed step once per PWM period; duty only changes on period boundaries.
module pio_pwm_driver #(
  parameter int PIO_WIDTH = 8,
  parameter int PRESCALE  = 4,
  parameter int RAMP_EN   = 1,
  parameter int RAMP_STEP = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [PIO_WIDTH-1:0] pio_i,
  output logic                 pwm_o,
  output logic [PIO_WIDTH-1:0] duty_o,
  output logic                 busy_o
);

  localparam logic [15:0]          PRE_MAX  = 16'(PRESCALE - 1);
  localparam logic [PIO_WIDTH-1:0] CNT_MAX  = {PIO_WIDTH{1'b1}};
  localparam logic [PIO_WIDTH-1:0] CNT_ONE  = PIO_WIDTH'(1'b1);
  localparam logic [PIO_WIDTH:0]   STEP_EXT = (PIO_WIDTH + 1)'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  // Ramp arithmetic is done one bit wider so the step never wraps past the target.
  function automatic logic [PIO_WIDTH-1:0] ramp_up(input logic [PIO_WIDTH-1:0] duty,
                                                   input logic [PIO_WIDTH-1:0] target);
    logic [PIO_WIDTH:0] sum;
    logic [PIO_WIDTH-1:0] res;
    sum = {1'b0, duty} + STEP_EXT;
    if (sum > {1'b0, target}) res = target;
    else                      res = sum[PIO_WIDTH-1:0];
    return res;
  endfunction

  function automatic logic [PIO_WIDTH-1:0] ramp_down(input logic [PIO_WIDTH-1:0] duty,
                                                     input logic [PIO_WIDTH-1:0] target);
    logic [PIO_WIDTH:0] gap;
    logic [PIO_WIDTH-1:0] res;
    gap = {1'b0, duty} - {1'b0, target};
    if (gap <= STEP_EXT) res = target;
    else                 res = duty - STEP_EXT[PIO_WIDTH-1:0];
    return res;
  endfunction

  function automatic state_t classify(input logic [PIO_WIDTH-1:0] duty,
                                      input logic [PIO_WIDTH-1:0] target);
    state_t st;
    if (duty < target)      st = UP;
    else if (duty > target) st = DOWN;
    else                    st = IDLE;
    return st;
  endfunction

  logic [15:0]          pre_r, pre_nxt_s;
  logic [PIO_WIDTH-1:0] cnt_r, cnt_nxt_s;
  logic [PIO_WIDTH-1:0] target_r;
  logic [PIO_WIDTH-1:0] duty_r, duty_nxt_s;
  logic                 pwm_r;
  state_t               state_r, state_nxt_s;
  logic                 tick_s, boundary_s;

  // Next-state logic: prescaler/counter advance, boundary duty update, direction state.
  always_comb begin
    tick_s     = (pre_r == PRE_MAX);
    boundary_s = tick_s && (cnt_r == CNT_MAX);
    pre_nxt_s  = pre_r;
    cnt_nxt_s  = cnt_r;
    duty_nxt_s = duty_r;
    if (tick_s) begin
      pre_nxt_s = 16'd0;
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      pre_nxt_s = pre_r + 16'd1;
      cnt_nxt_s = cnt_r;
    end
    if (boundary_s) begin
      if (RAMP_EN == 32'sd0) begin
        duty_nxt_s = target_r;
      end else begin
        case (state_r)
          UP:      duty_nxt_s = ramp_up(duty_r, target_r);
          DOWN:    duty_nxt_s = ramp_down(duty_r, target_r);
          IDLE:    duty_nxt_s = duty_r;
          default: duty_nxt_s = duty_r;
        endcase
      end
    end else begin
      duty_nxt_s = duty_r;
    end
    // Registered state always mirrors the comparison of the registered duty and target.
    state_nxt_s = classify(duty_nxt_s, pio_i);
  end

  // State registers; the duty update and counter wrap share the boundary edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pre_r    <= 16'd0;
      cnt_r    <= {PIO_WIDTH{1'b0}};
      target_r <= {PIO_WIDTH{1'b0}};
      duty_r   <= {PIO_WIDTH{1'b0}};
      pwm_r    <= 1'b0;
      state_r  <= IDLE;
    end else begin
      pre_r    <= pre_nxt_s;
      cnt_r    <= cnt_nxt_s;
      target_r <= pio_i;
      duty_r   <= duty_nxt_s;
      pwm_r    <= (cnt_r < duty_r);
      state_r  <= state_nxt_s;
    end
  end

  assign pwm_o  = pwm_r;
  assign duty_o = duty_r;
  assign busy_o = (state_r != IDLE);

endmodule

// File: tb/tb_pio_pwm_driver.sv
// Self-checking bench: three driver variants against an arithmetic reference model,
// plus table-driven ramp checks and hand-written boundary/reset sequences.
module tb_pio_pwm_driver;

  localparam int NI = 3;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    pio  [NI];
  logic [NI-1:0] pwm;
  logic [NI-1:0] busy;
  logic [7:0]    duty [NI];

  int n_chk  = 0;
  int n_fail = 0;

  int   n_m    [NI];
  int   duty_m [NI];
  int   tgt_m  [NI];
  logic pwm_m  [NI];

  typedef struct {
    int   wait_cyc;
    int   exp_duty;
    logic exp_busy;
  } row_t;

  always #5 clk = ~clk;

  pio_pwm_driver #(.PIO_WIDTH(8), .PRESCALE(1), .RAMP_EN(0), .RAMP_STEP(1)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .pio_i(pio[0]), .pwm_o(pwm[0]), .duty_o(duty[0]), .busy_o(busy[0]));
  pio_pwm_driver #(.PIO_WIDTH(8), .PRESCALE(1), .RAMP_EN(1), .RAMP_STEP(16)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .pio_i(pio[1]), .pwm_o(pwm[1]), .duty_o(duty[1]), .busy_o(busy[1]));
  pio_pwm_driver #(.PIO_WIDTH(8), .PRESCALE(3), .RAMP_EN(1), .RAMP_STEP(7)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .pio_i(pio[2]), .pwm_o(pwm[2]), .duty_o(duty[2]), .busy_o(busy[2]));

  function automatic int pre_of(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic int en_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int step_of(input int i);
    return (i == 1) ? 16 : ((i == 2) ? 7 : 1);
  endfunction

  // Move toward the target by at most one step, never past it.
  function automatic int next_duty(input int d, input int t, input int en, input int st);
    if (en == 0) return t;
    if (t > d) return (d + st < t) ? d + st : t;
    if (t < d) return (d - st > t) ? d - st : t;
    return d;
  endfunction

  // Reference model: n_m counts clock edges since reset release.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NI; i++) begin
        n_m[i] <= 0; duty_m[i] <= 0; tgt_m[i] <= 0; pwm_m[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        pwm_m[i] <= (((n_m[i] / pre_of(i)) % 256) < duty_m[i]);
        n_m[i]   <= n_m[i] + 1;
        if (((n_m[i] + 1) % (256 * pre_of(i))) == 0)
          duty_m[i] <= next_duty(duty_m[i], tgt_m[i], en_of(i), step_of(i));
        tgt_m[i] <= int'(pio[i]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, on the falling edge, all variants are compared against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("model%0d_pwm", i), int'(pwm[i]), int'(pwm_m[i]));
      chk($sformatf("model%0d_duty", i), int'(duty[i]), duty_m[i]);
      chk($sformatf("model%0d_busy", i), int'(busy[i]), (duty_m[i] != tgt_m[i]) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    rstn = 1'b0;
    cyc(2);
    pio[0] = p0; pio[1] = p1; pio[2] = p2;
    rstn = 1'b1;
  endtask

  task automatic count_high(input int i, input int n, output int c);
    c = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      c += int'(pwm[i]);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s%0d_pwm", tag, i), int'(pwm[i]), 0);
      chk($sformatf("%s%0d_duty", tag, i), int'(duty[i]), 0);
      chk($sformatf("%s%0d_busy", tag, i), int'(busy[i]), 0);
    end
  endtask

  row_t tab [26];
  int   dl  [13] = '{16, 32, 48, 64, 80, 96, 112, 128, 144, 160, 176, 192, 200};

  initial begin
    int hc;
    int p;
    for (int k = 0; k < 13; k++) begin
      tab[2*k].wait_cyc   = 255;
      tab[2*k].exp_duty   = (k == 0) ? 0 : dl[k-1];
      tab[2*k].exp_busy   = 1'b1;
      tab[2*k+1].wait_cyc = 1;
      tab[2*k+1].exp_duty = dl[k];
      tab[2*k+1].exp_busy = (k != 12);
    end
    for (int i = 0; i < NI; i++) pio[i] = 8'd0;

    // Reset state, including a nonzero target presented while held in reset.
    cyc(3);
    chk_zero("rst");
    for (int i = 0; i < NI; i++) pio[i] = 8'd200;
    cyc(2);
    chk_zero("rst_pio");

    // Zero target: output stays low indefinitely.
    restart(8'd0, 8'd0, 8'd0);
    cyc(600);
    chk_zero("idle");
    count_high(1, 300, hc);
    chk("idle_high_count", hc, 0);

    // Jump to 64 on variant 0 while variant 1 ramps to 200.
    restart(8'd64, 8'd200, 8'd0);
    for (int r = 0; r < 26; r++) begin
      cyc(tab[r].wait_cyc);
      chk($sformatf("ramp_duty_r%0d", r), int'(duty[1]), tab[r].exp_duty);
      chk($sformatf("ramp_busy_r%0d", r), int'(busy[1]), int'(tab[r].exp_busy));
    end
    chk("jump_duty", int'(duty[0]), 64);
    chk("jump_busy", int'(busy[0]), 0);
    count_high(0, 256, hc);
    chk("jump_high_count", hc, 64);
    count_high(1, 256, hc);
    chk("ramp_high_count", hc, 200);

    // Reversal mid-ramp: 96 heading to 200, target changed to 40.
    restart(8'd0, 8'd200, 8'd0);
    cyc(1536);
    chk("rev_duty_96", int'(duty[1]), 96);
    cyc(64);
    pio[1] = 8'd40;
    cyc(191);
    chk("rev_hold_96", int'(duty[1]), 96);
    chk("rev_busy", int'(busy[1]), 1);
    cyc(1);
    chk("rev_duty_80", int'(duty[1]), 80);
    cyc(256);
    chk("rev_duty_64", int'(duty[1]), 64);
    cyc(256);
    chk("rev_duty_48", int'(duty[1]), 48);
    cyc(256);
    chk("rev_duty_40", int'(duty[1]), 40);
    chk("rev_busy_done", int'(busy[1]), 0);

    // Target change on the clock of a boundary applies only one boundary later.
    restart(8'd64, 8'd0, 8'd0);
    cyc(256);
    chk("bnd_duty_first", int'(duty[0]), 64);
    cyc(255);
    pio[0] = 8'd128;
    cyc(1);
    chk("bnd_duty_unchanged", int'(duty[0]), 64);
    count_high(0, 256, hc);
    chk("bnd_high_old", hc, 64);
    chk("bnd_duty_new", int'(duty[0]), 128);
    count_high(0, 256, hc);
    chk("bnd_high_new", hc, 128);

    // Reset pulse mid-ramp and mid-period, then restart of the ramp from zero.
    restart(8'd0, 8'd255, 8'd0);
    cyc(2048);
    chk("rp_duty_128", int'(duty[1]), 128);
    cyc(52);
    chk("rp_pwm_high", int'(pwm[1]), 1);
    rstn = 1'b0;
    #1;
    chk_zero("rp_async");
    cyc(3);
    chk_zero("rp_held");
    rstn = 1'b1;
    cyc(1);
    chk("rp_first_pwm", int'(pwm[1]), 0);
    chk("rp_first_duty", int'(duty[1]), 0);
    chk("rp_first_busy", int'(busy[1]), 1);
    cyc(254);
    chk("rp_pre_bnd", int'(duty[1]), 0);
    cyc(1);
    chk("rp_bnd", int'(duty[1]), 16);

    // Random targets on all variants, compared cycle by cycle against the model.
    restart(8'($urandom), 8'($urandom), 8'($urandom));
    for (int c = 0; c < 20000; c++) begin
      cyc(1);
      if (c == 9000) begin
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
      end
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          p = int'($urandom_range(0, 3));
          case (p)
            0:       pio[i] = 8'd0;
            1:       pio[i] = 8'd255;
            default: pio[i] = 8'($urandom);
          endcase
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_pwm_driver.md
PIO_PWM_DRIVER -- requirements
Module: pio_pwm_driver

Interface
REQ-001 Parameter PIO_WIDTH, default 8: width of pio_i and of every duty quantity.
REQ-002 Parameter PRESCALE, default 4: clocks per PWM counter step; legal range 1..65535.
REQ-003 Parameter RAMP_EN, default 1: 1 = duty ramps toward target; 0 = duty jumps to target.
REQ-004 Parameter RAMP_STEP, default 1: duty change per PWM period when ramping; legal range 1..2**PIO_WIDTH-1.
REQ-005 Port clk_i  input  1: single clock; all state is on its rising edge.
REQ-006 Port rstn_i  input  1: asynchronous active-low reset, asserted asynchronously, deasserted synchronously to clk_i by the upstream synchronizer.
REQ-007 Port pio_i  input  PIO_WIDTH: target duty word from the upstream PIO, in the clk_i domain.
REQ-008 Port pwm_o  output  1: registered PWM output.
REQ-009 Port duty_o  output  PIO_WIDTH: duty value currently applied.
REQ-010 Port busy_o  output  1: high while the applied duty differs from the target.

Function
REQ-011 pio_i SHALL be registered into target_q every clock (1-cycle latency); there is no other capture condition.
REQ-012 Prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick = (prescaler == PRESCALE-1); PRESCALE=1 gives a tick every clock.
REQ-013 PWM counter cnt (PIO_WIDTH bits) SHALL increment on tick only, wrapping 2**PIO_WIDTH-1 -> 0; period = 2**PIO_WIDTH * PRESCALE clocks.
REQ-014 Period boundary SHALL be defined as tick while cnt == 2**PIO_WIDTH-1; duty_q changes only on a boundary, never mid-period.
REQ-015 pwm_o SHALL be registered as (cnt < duty_q), evaluated every clock; duty 0 -> pwm_o constantly 0; duty 255 -> high for 255 of 256 counter steps.
REQ-016 FSM states: IDLE (duty_q == target_q), UP (duty_q < target_q), DOWN (duty_q > target_q); state is re-evaluated every clock from duty_q and target_q.
REQ-017 On a boundary in UP with RAMP_EN=1: duty_q <= min(duty_q + RAMP_STEP, target_q), computed in PIO_WIDTH+1 bits with no wrap-around.
REQ-018 On a boundary in DOWN with RAMP_EN=1: duty_q <= max(duty_q - RAMP_STEP, target_q), with no underflow.
REQ-019 On a boundary with RAMP_EN=0: duty_q <= target_q in one step.
REQ-020 Target changes mid-ramp SHALL take effect at the next boundary, including reversal of direction; no overshoot of the new target.
REQ-021 A target change coinciding with a boundary SHALL NOT be seen at that boundary (target_q is one cycle old); it applies at the following boundary.
REQ-022 busy_o SHALL be combinational (state != IDLE); duty_o SHALL equal duty_q.
REQ-023 The duty_q update and the cnt wrap on a boundary SHALL occur on the same edge, so the new period starts with the new duty.

Reset
REQ-024 While rstn_i is low: prescaler=0, cnt=0, target_q=0, duty_q=0, pwm_o=0, duty_o=0, busy_o=0, state IDLE.
REQ-025 Reset asserted mid-ramp or mid-period SHALL clear all state immediately; after release the first boundary occurs 2**PIO_WIDTH*PRESCALE clocks later.
REQ-026 No output SHALL glitch high during reset or on the first clock after release.

Verification (PRESCALE=1, PIO_WIDTH=8 unless stated)
REQ-027 Reset, pio_i=0 -> pwm_o=0 indefinitely; busy_o=0; duty_o=0.
REQ-028 RAMP_EN=0, pio_i=64 held from reset release -> duty_o=64 after the first boundary (clock 256); then pwm_o is high for exactly 64 of every 256 clocks, and busy_o=0.
REQ-029 RAMP_EN=1, RAMP_STEP=16, pio_i 0->200 -> duty_o steps 16,32,...,192,200 on successive boundaries (13 boundaries, no overshoot); busy_o falls on the edge duty_o reaches 200.
REQ-030 RAMP_EN=1, ramp toward 200 reversed to pio_i=40 while duty_o=96 -> duty_o goes 80,64,48,40 on the next boundaries, then busy_o=0.
REQ-031 pio_i changed on the clock of a boundary -> duty_o unchanged at that boundary; updated at the next boundary; the PWM high time within any single period is never torn.
REQ-032 rstn_i pulsed low mid-ramp (duty_o=128, target 255) -> all outputs 0 at once; after release with pio_i=255 the ramp restarts from 0.
